// File: rtl/apb2axi_cpl_queue.sv
// Completion queue: round-robin merge of read/write AXI completions into an in-order FIFO for the directory.
// Optional macro APB2AXI_CQ_BYPASS_EN lets a completion pushed into an empty queue reach the directory in the same cycle.
module apb2axi_cpl_queue #(
    parameter int CQ_DEPTH    = 4,
    parameter int ERR_CNT_W   = 8,
    parameter int TAG_W       = 8,
    parameter int NUM_BEATS_W = 8,
    localparam int ENTRY_W    = TAG_W + 2 + NUM_BEATS_W + 1,
    localparam int CNT_W      = $clog2(CQ_DEPTH + 1),
    localparam int PTR_W      = $clog2(CQ_DEPTH)
) (
    input  logic                 pclk,
    input  logic                 presetn,
    input  logic                 rd_cq_cpl_vld,
    input  logic [ENTRY_W-1:0]   rd_cq_cpl_entry,
    output logic                 rd_cq_cpl_ready,
    input  logic                 wr_cq_cpl_vld,
    input  logic [ENTRY_W-1:0]   wr_cq_cpl_entry,
    output logic                 wr_cq_cpl_ready,
    output logic                 cq_dir_cpl_vld,
    output logic [ENTRY_W-1:0]   cq_dir_cpl_entry,
    input  logic                 cq_dir_cpl_ready,
    output logic [CNT_W-1:0]     cq_count,
    output logic [ERR_CNT_W-1:0] cq_err_cnt,
    input  logic                 cq_err_cnt_clr
);

    // Entry layout (MSB..LSB): {tag, resp[1:0], num_beats, error}
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CQ_DEPTH);

    logic [ENTRY_W-1:0]   mem_q [CQ_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [ERR_CNT_W-1:0] err_q, err_d;
    logic                 rr_wr_pri_q, rr_wr_pri_d;

    logic                 full, empty;
    logic                 grant_rd, grant_wr;
    logic                 push, pop, store, bypass_take;
    logic [ENTRY_W-1:0]   push_entry;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);

    assign grant_rd = rd_cq_cpl_vld && (!wr_cq_cpl_vld || !rr_wr_pri_q);
    assign grant_wr = wr_cq_cpl_vld && (!rd_cq_cpl_vld || rr_wr_pri_q);

    // Readys are forced low during reset; a full queue refuses even when popping this cycle.
    assign rd_cq_cpl_ready = presetn && grant_rd && !full;
    assign wr_cq_cpl_ready = presetn && grant_wr && !full;

    assign push       = (rd_cq_cpl_vld && rd_cq_cpl_ready) || (wr_cq_cpl_vld && wr_cq_cpl_ready);
    assign push_entry = grant_wr ? wr_cq_cpl_entry : rd_cq_cpl_entry;
    assign pop        = !empty && cq_dir_cpl_ready;

`ifdef APB2AXI_CQ_BYPASS_EN
    logic bypass;
    assign bypass           = push && empty;
    assign bypass_take      = bypass && cq_dir_cpl_ready;
    assign cq_dir_cpl_vld   = !empty || bypass;
    assign cq_dir_cpl_entry = bypass ? push_entry : mem_q[rd_ptr_q];
`else
    assign bypass_take      = 1'b0;
    assign cq_dir_cpl_vld   = !empty;
    assign cq_dir_cpl_entry = mem_q[rd_ptr_q];
`endif

    assign store      = push && !bypass_take;
    assign cq_count   = count_q;
    assign cq_err_cnt = err_q;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        err_d       = err_q;
        rr_wr_pri_d = rr_wr_pri_q;

        if (store) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;

        if (store && !pop)      count_d = count_q + 1'b1;
        else if (!store && pop) count_d = count_q - 1'b1;

        // After a contested push the loser gets priority next time.
        if (push && rd_cq_cpl_vld && wr_cq_cpl_vld) rr_wr_pri_d = grant_rd;

        if (cq_err_cnt_clr)                                 err_d = '0;
        else if (push && push_entry[0] && (err_q != '1))    err_d = err_q + 1'b1;
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            err_q       <= '0;
            rr_wr_pri_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            err_q       <= err_d;
            rr_wr_pri_q <= rr_wr_pri_d;
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            for (int i = 0; i < CQ_DEPTH; i++) mem_q[i] <= '0;
        end else if (store) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

endmodule
